// File: rtl/lane_skew_pkg.sv
// Shared types and the per-lane delay rule for the lane skew/de-skew engine.
package lane_skew_pkg;

  typedef enum logic {
    MODE_SKEW   = 1'b0,
    MODE_DESKEW = 1'b1
  } mode_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  // SKEW delays lane i by i*step; DESKEW mirrors it so the last lane is undelayed.
  function automatic int delay_of(input int lane, input mode_e mode, input int step,
                                  input int lanes);
    return (mode == MODE_SKEW) ? lane * step : (lanes - 1 - lane) * step;
  endfunction

endpackage

// File: rtl/lane_skew_unit_line.sv
// One lane: MAXD-deep shift of {valid, tag, data} with a runtime tap; tap 0 bypasses the registers.
module lane_delay_line #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int MAXD   = 15,
  parameter int TW     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [TW-1:0]     tap,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int PW = TAG_W + DATA_W;

  logic [MAXD:1] vld_q, vld_d;
  logic [PW-1:0] pay_q [1:MAXD];
  logic [PW-1:0] pay_d [1:MAXD];

  always_comb begin
    vld_d    = '0;
    vld_d[1] = in_valid & ~flush;
    pay_d[1] = {in_tag, in_data};
    for (int k = 2; k <= MAXD; k++) begin
      vld_d[k] = vld_q[k-1] & ~flush;
      pay_d[k] = pay_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int k = 1; k <= MAXD; k++) pay_q[k] <= '0;
    end else begin
      vld_q <= vld_d;
      pay_q <= pay_d;
    end
  end

  always_comb begin
    if (tap == '0) begin
      out_valid           = in_valid;
      {out_tag, out_data} = {in_tag, in_data};
    end else begin
      out_valid           = vld_q[tap];
      {out_tag, out_data} = pay_q[tap];
    end
  end

endmodule

// File: rtl/lane_skew_unit.sv
// Runtime-configurable skew/de-skew engine: per-lane delay lines, flight timer,
// drain-before-reconfigure FSM, aligned-valid and sticky misalignment flag.
module lane_skew_unit
  import lane_skew_pkg::*;
#(
  parameter int LANES  = 16,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int STEP   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_load,
  input  logic                    cfg_mode,
  input  logic [LANES-1:0]        cfg_mask,
  output logic                    cfg_busy,
  input  logic                    flush,
  input  logic [LANES-1:0]        in_valid,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic [LANES*TAG_W-1:0]  in_tag,
  output logic                    in_ready,
  output logic [LANES-1:0]        out_valid,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [LANES*TAG_W-1:0]  out_tag,
  output logic                    aligned_valid,
  output logic                    idle,
  output logic                    err_misalign
);

  localparam int MAXD = (LANES - 1) * STEP;
  localparam int TW   = $clog2(MAXD + 1);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d, pend_mode_q, pend_mode_d;
  logic [LANES-1:0] mask_q, mask_d, pend_mask_q, pend_mask_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             err_q, err_d;
  logic             accept;
  logic [LANES-1:0] lane_vin;
  logic [LANES-1:0] masked_v;

  // Masked-off lanes never carry a valid beat into their delay line.
  assign lane_vin = in_valid & mask_q & {LANES{in_ready}};

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [TW-1:0] tap;
    assign tap = TW'(delay_of(gi, mode_q, STEP, LANES));

    lane_delay_line #(
      .DATA_W(DATA_W),
      .TAG_W (TAG_W),
      .MAXD  (MAXD),
      .TW    (TW)
    ) u_line (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .tap      (tap),
      .in_valid (lane_vin[gi]),
      .in_data  (in_data[gi*DATA_W +: DATA_W]),
      .in_tag   (in_tag[gi*TAG_W +: TAG_W]),
      .out_valid(out_valid[gi]),
      .out_data (out_data[gi*DATA_W +: DATA_W]),
      .out_tag  (out_tag[gi*TAG_W +: TAG_W])
    );
  end

  // Flight timer covers the deepest tap, so idle means nothing can still emerge.
  always_comb begin
    accept   = (|in_valid) & in_ready;
    idle     = (timer_q == '0) & ~accept;
    masked_v = out_valid & mask_q;
    if (flush)                timer_d = '0;
    else if (accept)          timer_d = TW'(MAXD);
    else if (timer_q != '0)   timer_d = timer_q - 1'b1;
    else                      timer_d = timer_q;
    err_d = err_q | ((mode_q == MODE_DESKEW) && (masked_v != '0) && (masked_v != mask_q));
    if (flush) err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    mask_d      = mask_q;
    pend_mode_d = pend_mode_q;
    pend_mask_d = pend_mask_q;
    if (flush) begin
      state_d = ST_RUN;
      if (state_q == ST_DRAIN) begin
        mode_d = pend_mode_q;
        mask_d = pend_mask_q;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (cfg_load) begin
            if (idle) begin
              mode_d = mode_e'(cfg_mode);
              mask_d = cfg_mask;
            end else begin
              pend_mode_d = mode_e'(cfg_mode);
              pend_mask_d = cfg_mask;
              state_d     = ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (cfg_load) begin
            pend_mode_d = mode_e'(cfg_mode);
            pend_mask_d = cfg_mask;
          end
          if (idle) begin
            mode_d  = cfg_load ? mode_e'(cfg_mode) : pend_mode_q;
            mask_d  = cfg_load ? cfg_mask : pend_mask_q;
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    in_ready      = (state_q == ST_RUN);
    cfg_busy      = (state_q == ST_DRAIN);
    aligned_valid = (&(out_valid | ~mask_q)) & (|mask_q);
    err_misalign  = err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= MODE_SKEW;
      mask_q      <= '1;
      pend_mode_q <= MODE_SKEW;
      pend_mask_q <= '1;
      timer_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      mask_q      <= mask_d;
      pend_mode_q <= pend_mode_d;
      pend_mask_q <= pend_mask_d;
      timer_q     <= timer_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_lane_skew_unit.sv
// Scoreboard bench for lane_skew_unit: LANES=4 with STEP=1 (u_dut) and STEP=2 (u_dut2) on shared inputs.
module tb_lane_skew_unit;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_load = 1'b0;
  logic         cfg_mode = 1'b0;
  logic [3:0]   cfg_mask = 4'hF;
  logic         flush = 1'b0;
  logic [3:0]   in_valid = 4'h0;
  logic [127:0] in_data = '0;
  logic [15:0]  in_tag = '0;

  logic         cfg_busy, in_ready, aligned_valid, idle, err_misalign;
  logic [3:0]   out_valid;
  logic [127:0] out_data;
  logic [15:0]  out_tag;
  logic         cfg_busy2, in_ready2, aligned_valid2, idle2, err_misalign2;
  logic [3:0]   out_valid2;
  logic [127:0] out_data2;
  logic [15:0]  out_tag2;

  lane_skew_unit #(.LANES(4), .DATA_W(32), .TAG_W(4), .STEP(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_mode(cfg_mode), .cfg_mask(cfg_mask),
    .cfg_busy(cfg_busy), .flush(flush), .in_valid(in_valid), .in_data(in_data), .in_tag(in_tag),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_tag(out_tag),
    .aligned_valid(aligned_valid), .idle(idle), .err_misalign(err_misalign));

  lane_skew_unit #(.LANES(4), .DATA_W(32), .TAG_W(4), .STEP(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_mode(cfg_mode), .cfg_mask(cfg_mask),
    .cfg_busy(cfg_busy2), .flush(flush), .in_valid(in_valid), .in_data(in_data), .in_tag(in_tag),
    .in_ready(in_ready2), .out_valid(out_valid2), .out_data(out_data2), .out_tag(out_tag2),
    .aligned_valid(aligned_valid2), .idle(idle2), .err_misalign(err_misalign2));

  always #5 clk = ~clk;

  typedef struct {
    int         lane;
    int         due;
    logic [31:0] data;
    logic [3:0]  tag;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   sel2 = 1'b0;
  bit   m_mode = 1'b0;
  logic [3:0] m_mask = 4'hF;
  int   m_step = 1;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every delivered beat must match the oldest expectation for its lane, on its due cycle.
  logic [3:0]   mov;
  logic [127:0] mod;
  logic [15:0]  mot;
  int           midx;
  always @(negedge clk) begin
    mov = sel2 ? out_valid2 : out_valid;
    mod = sel2 ? out_data2 : out_data;
    mot = sel2 ? out_tag2 : out_tag;
    for (int i = 0; i < 4; i++) begin
      if (mov[i] === 1'b1) begin
        midx = -1;
        for (int j = 0; j < sbq.size(); j++)
          if (midx < 0 && sbq[j].lane == i) midx = j;
        checks++;
        if (midx < 0) begin
          errors++;
          $display("FAIL beat_unexpected: lane %0d cyc %0d data %h", i, cyc, mod[i*32 +: 32]);
        end else begin
          if (sbq[midx].due != cyc || mod[i*32 +: 32] !== sbq[midx].data || mot[i*4 +: 4] !== sbq[midx].tag) begin
            errors++;
            $display("FAIL beat lane %0d: got cyc %0d data %h tag %h, expected cyc %0d data %h tag %h",
                     i, cyc, mod[i*32 +: 32], mot[i*4 +: 4], sbq[midx].due, sbq[midx].data, sbq[midx].tag);
          end
          sbq.delete(midx);
        end
      end
    end
    for (int j = sbq.size() - 1; j >= 0; j--) begin
      if (sbq[j].due <= cyc) begin
        checks++;
        errors++;
        $display("FAIL beat_missing: lane %0d due cyc %0d data %h not seen by cyc %0d",
                 sbq[j].lane, sbq[j].due, sbq[j].data, cyc);
        sbq.delete(j);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one cycle of lane inputs and records the expected emergence of each enabled beat.
  task automatic drive(input logic [3:0] v, input int base);
    exp_t e;
    in_valid = v;
    for (int i = 0; i < 4; i++) begin
      in_data[i*32 +: 32] = 32'(base + i);
      in_tag[i*4 +: 4]    = 4'(base + i);
      if (v[i] && m_mask[i]) begin
        e.lane = i;
        e.due  = cyc + (m_mode ? (3 - i) : i) * m_step;
        e.data = 32'(base + i);
        e.tag  = 4'(base + i);
        sbq.push_back(e);
      end
    end
  endtask

  task automatic do_cfg(input bit mode, input logic [3:0] mask);
    cfg_load = 1'b1;
    cfg_mode = mode;
    cfg_mask = mask;
    tick();
    cfg_load = 1'b0;
    m_mode = mode;
    m_mask = mask;
  endtask

  task automatic wait_idle(input bit sel);
    int n = 0;
    while (((sel ? idle2 : idle) !== 1'b1) && n < 64) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 64) begin
      errors++;
      $display("FAIL wait_idle: idle still low after %0d cycles", n);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 6;
    if (out_valid !== 4'h0)     begin errors++; $display("FAIL reset_out_valid: got %b expected 0000", out_valid); end
    if (aligned_valid !== 1'b0) begin errors++; $display("FAIL reset_aligned: got %b expected 0", aligned_valid); end
    if (err_misalign !== 1'b0)  begin errors++; $display("FAIL reset_err: got %b expected 0", err_misalign); end
    if (cfg_busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b expected 0", cfg_busy); end
    if (in_ready !== 1'b1)      begin errors++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
    if (idle !== 1'b1)          begin errors++; $display("FAIL reset_idle: got %b expected 1", idle); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_skew();
    for (int k = 0; k < 6; k++) begin
      if (k == 0) drive(4'hF, 10);
      else        in_valid = 4'h0;
      @(negedge clk);
      checks += 2;
      if (idle !== (k >= 4))      begin errors++; $display("FAIL skew_idle k=%0d: got %b expected %b", k, idle, (k >= 4)); end
      if (aligned_valid !== 1'b0) begin errors++; $display("FAIL skew_aligned k=%0d: got %b expected 0", k, aligned_valid); end
      tick();
    end
  endtask

  task automatic test_deskew();
    logic exp_al;
    wait_idle(0);
    do_cfg(1'b1, 4'hF);
    for (int k = 0; k < 7; k++) begin
      if (k < 4) drive(4'(1 << k), 20);
      else       in_valid = 4'h0;
      @(negedge clk);
      exp_al = (k == 3);
      checks++;
      if (aligned_valid !== exp_al) begin errors++; $display("FAIL deskew_aligned k=%0d: got %b expected %b", k, aligned_valid, exp_al); end
      tick();
    end
    checks++;
    if (err_misalign !== 1'b0) begin errors++; $display("FAIL deskew_err: got %b expected 0", err_misalign); end
  endtask

  task automatic test_mask();
    logic exp_al;
    wait_idle(0);
    do_cfg(1'b1, 4'b0101);
    for (int k = 0; k < 6; k++) begin
      drive((k == 0) ? 4'b0001 : (k == 2) ? 4'b0100 : 4'b0000, 30);
      @(negedge clk);
      exp_al = (k == 3);
      checks++;
      if (aligned_valid !== exp_al) begin errors++; $display("FAIL mask_aligned k=%0d: got %b expected %b", k, aligned_valid, exp_al); end
      tick();
    end
    in_valid = 4'h0;
    checks++;
    if (err_misalign !== 1'b0) begin errors++; $display("FAIL mask_err: got %b expected 0", err_misalign); end
  endtask

  task automatic test_misalign_flush();
    logic exp_err;
    wait_idle(0);
    do_cfg(1'b1, 4'hF);
    for (int k = 0; k < 8; k++) begin
      drive((k == 0) ? 4'b0001 : (k == 2) ? 4'b0110 : (k == 3) ? 4'b1000 : 4'b0000, 60);
      @(negedge clk);
      exp_err = (k >= 4);
      checks += 2;
      if (err_misalign !== exp_err) begin errors++; $display("FAIL misalign_err k=%0d: got %b expected %b", k, err_misalign, exp_err); end
      if (aligned_valid !== 1'b0)   begin errors++; $display("FAIL misalign_aligned k=%0d: got %b expected 0", k, aligned_valid); end
      tick();
    end
    drive(4'hF, 70);
    @(negedge clk);
    tick();
    in_valid = 4'h0;
    flush = 1'b1;
    for (int j = sbq.size() - 1; j >= 0; j--)
      if (sbq[j].due > cyc) sbq.delete(j);
    @(negedge clk);
    checks++;
    if (err_misalign !== 1'b1) begin errors++; $display("FAIL flush_err_before: got %b expected 1", err_misalign); end
    tick();
    flush = 1'b0;
    @(negedge clk);
    checks += 3;
    if (out_valid !== 4'h0)    begin errors++; $display("FAIL flush_out_valid: got %b expected 0000", out_valid); end
    if (err_misalign !== 1'b0) begin errors++; $display("FAIL flush_err_after: got %b expected 0", err_misalign); end
    if (idle !== 1'b1)         begin errors++; $display("FAIL flush_idle: got %b expected 1", idle); end
    tick();
  endtask

  task automatic test_drain();
    wait_idle(0);
    do_cfg(1'b0, 4'hF);
    drive(4'hF, 40);
    @(negedge clk);
    tick();
    in_valid = 4'h0;
    cfg_load = 1'b1;
    cfg_mode = 1'b1;
    cfg_mask = 4'hF;
    @(negedge clk);
    checks += 2;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL drain_req_ready: got %b expected 1", in_ready); end
    if (cfg_busy !== 1'b0) begin errors++; $display("FAIL drain_req_busy: got %b expected 0", cfg_busy); end
    tick();
    cfg_load = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      checks += 2;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL drain_ready k=%0d: got %b expected 0", k, in_ready); end
      if (cfg_busy !== 1'b1) begin errors++; $display("FAIL drain_busy k=%0d: got %b expected 1", k, cfg_busy); end
      tick();
    end
    m_mode = 1'b1;
    drive(4'hF, 80);
    @(negedge clk);
    checks += 2;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL drain_done_ready: got %b expected 1", in_ready); end
    if (cfg_busy !== 1'b0) begin errors++; $display("FAIL drain_done_busy: got %b expected 0", cfg_busy); end
    tick();
    in_valid = 4'h0;
    wait_idle(0);
  endtask

  task automatic test_step2_reset();
    logic [3:0] exp_v;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    sel2 = 1'b1;
    m_step = 2;
    m_mode = 1'b0;
    m_mask = 4'hF;
    for (int k = 0; k < 8; k++) begin
      if (k == 0) drive(4'hF, 50);
      else        in_valid = 4'h0;
      @(negedge clk);
      exp_v = (k % 2 == 0 && k <= 6) ? 4'(1 << (k / 2)) : 4'h0;
      checks++;
      if (out_valid2 !== exp_v) begin errors++; $display("FAIL step2_valid k=%0d: got %b expected %b", k, out_valid2, exp_v); end
      tick();
    end
    wait_idle(1);
    drive(4'hF, 90);
    @(negedge clk);
    tick();
    in_valid = 4'h0;
    @(negedge clk);
    tick();
    #2;
    checks++;
    if (out_valid2 !== 4'b0010) begin errors++; $display("FAIL arst_pre: got %b expected 0010", out_valid2); end
    rst_n = 1'b0;
    sbq.delete();
    #1;
    checks += 4;
    if (out_valid2 !== 4'h0)    begin errors++; $display("FAIL arst_valid: got %b expected 0000", out_valid2); end
    if (idle2 !== 1'b1)         begin errors++; $display("FAIL arst_idle: got %b expected 1", idle2); end
    if (err_misalign2 !== 1'b0) begin errors++; $display("FAIL arst_err: got %b expected 0", err_misalign2); end
    if (cfg_busy2 !== 1'b0)     begin errors++; $display("FAIL arst_busy: got %b expected 0", cfg_busy2); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      @(negedge clk);
      checks++;
      if (out_valid2 !== 4'h0) begin errors++; $display("FAIL arst_after k=%0d: got %b expected 0000", k, out_valid2); end
    end
    tick();
    do_cfg(1'b0, 4'h0);
    for (int k = 0; k < 10; k++) begin
      drive(4'hF, 100);
      @(negedge clk);
      checks += 2;
      if (aligned_valid2 !== 1'b0) begin errors++; $display("FAIL mask0_aligned k=%0d: got %b expected 0", k, aligned_valid2); end
      if (in_ready2 !== 1'b1)      begin errors++; $display("FAIL mask0_ready k=%0d: got %b expected 1", k, in_ready2); end
      tick();
    end
    in_valid = 4'h0;
  endtask

  initial begin
    test_reset();
    test_skew();
    test_deskew();
    test_mask();
    test_misalign_flush();
    test_drain();
    test_step2_reset();
    repeat (4) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
